temp_sensor_reader: RTL and testbench

//   Upstream stage of the fire-alarm mainboard. Polls a serial thermocouple converter

---
 rtl/temp_sensor_reader.sv | 159 +++++++++++++++
 tb/tb_temp_sensor_reader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/temp_sensor_reader.sv
// Polls a MAX6675-style thermocouple converter over read-only SPI and reports temperature in 0.1 degC.
// Optional TEMP_AVG_EN build adds a 4-sample moving average on good readings.
`timescale 1ns/1ps

module temp_sensor_reader #(
    parameter int INPUT_CLK_FREQ = 50_000_000,
    parameter int SCLK_FREQ      = 1_000_000,
    parameter int SAMPLE_RATE_HZ = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sensor_miso,
    output logic        sensor_cs_n,
    output logic        sensor_sclk,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        sensor_fault
);

    localparam int HALF_LIM    = INPUT_CLK_FREQ / (2 * SCLK_FREQ) - 1;
    localparam int TICK_PERIOD = INPUT_CLK_FREQ / SAMPLE_RATE_HZ;
    localparam int HALF_W      = ($clog2(HALF_LIM + 1) > 0) ? $clog2(HALF_LIM + 1) : 1;
    localparam int TICK_W      = ($clog2(TICK_PERIOD) > 0) ? $clog2(TICK_PERIOD) : 1;

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CONVERT} state_t;

    state_t              state_reg;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic                tick_reg;
    logic [HALF_W-1:0]   half_cnt_reg;
    logic [3:0]          bit_cnt_reg;
    // Only frame bits [14:2] are kept: {raw12, open flag}
    logic [12:0]         data_reg;
    logic [15:0]         temp_data_reg;
    logic                temp_valid_reg;
    logic                sensor_fault_reg;
    logic                cs_n_reg;
    logic                sclk_reg;
    logic [15:0]         sample_next;
    logic [15:0]         result_next;

    assign sensor_cs_n  = cs_n_reg;
    assign sensor_sclk  = sclk_reg;
    assign temp_data    = temp_data_reg;
    assign temp_valid   = temp_valid_reg;
    assign sensor_fault = sensor_fault_reg;

    assign sample_next = 16'(({4'd0, data_reg[12:1]} * 16'd5) >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg <= '0;
            tick_reg     <= 1'b0;
        end else if (tick_cnt_reg == TICK_W'(TICK_PERIOD - 1)) begin
            tick_cnt_reg <= '0;
            tick_reg     <= 1'b1;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
            tick_reg     <= 1'b0;
        end
    end

`ifdef TEMP_AVG_EN
    // Three most recent good samples; with the incoming one they form the 4-entry window.
    logic [2:0][15:0] win_reg;
    logic             loaded_reg;
    logic [17:0]      sum_next;
    logic             good_strobe;

    assign good_strobe = (state_reg == CONVERT) && !data_reg[0];
    assign sum_next    = 18'(sample_next) + 18'(win_reg[0]) + 18'(win_reg[1]) + 18'(win_reg[2]);
    assign result_next = loaded_reg ? 16'(sum_next >> 2) : sample_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_reg    <= '0;
            loaded_reg <= 1'b0;
        end else if (good_strobe) begin
            win_reg    <= loaded_reg ? {win_reg[1:0], sample_next} : {3{sample_next}};
            loaded_reg <= 1'b1;
        end
    end
`else
    assign result_next = sample_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cs_n_reg         <= 1'b1;
            sclk_reg         <= 1'b0;
            half_cnt_reg     <= '0;
            bit_cnt_reg      <= '0;
            data_reg         <= '0;
            temp_data_reg    <= '0;
            temp_valid_reg   <= 1'b0;
            sensor_fault_reg <= 1'b0;
        end else begin
            temp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tick_reg) begin
                        cs_n_reg     <= 1'b0;
                        half_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        state_reg    <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (half_cnt_reg == HALF_W'(HALF_LIM)) begin
                        // First rising edge carries the dummy bit, nothing captured.
                        half_cnt_reg <= '0;
                        sclk_reg     <= 1'b1;
                        state_reg    <= SHIFT;
                    end else begin
                        half_cnt_reg <= half_cnt_reg + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_cnt_reg == HALF_W'(HALF_LIM)) begin
                        half_cnt_reg <= '0;
                        sclk_reg     <= ~sclk_reg;
                        if (sclk_reg) begin
                            if (bit_cnt_reg == 4'd15)
                                state_reg <= CS_HOLD;
                            else
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end else if (bit_cnt_reg >= 4'd1 && bit_cnt_reg <= 4'd13) begin
                            data_reg <= {data_reg[11:0], sensor_miso};
                        end
                    end else begin
                        half_cnt_reg <= half_cnt_reg + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (half_cnt_reg == HALF_W'(HALF_LIM)) begin
                        half_cnt_reg <= '0;
                        cs_n_reg     <= 1'b1;
                        state_reg    <= CONVERT;
                    end else begin
                        half_cnt_reg <= half_cnt_reg + 1'b1;
                    end
                end
                CONVERT: begin
                    state_reg <= IDLE;
                    if (data_reg[0]) begin
                        sensor_fault_reg <= 1'b1;
                    end else begin
                        sensor_fault_reg <= 1'b0;
                        temp_data_reg    <= result_next;
                        temp_valid_reg   <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed + randomized bench for temp_sensor_reader with a converter slave model and a
// behavioural temperature model (TEMP_AVG_EN aware).
`timescale 1ns/1ps

module tb_temp_sensor_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sensor_miso = 1'b0;
    logic        sensor_cs_n;
    logic        sensor_sclk;
    logic [15:0] temp_data;
    logic        temp_valid;
    logic        sensor_fault;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [15:0] cur_frame = 16'h0000;
    int          rise_cnt  = 0;
    int          viol_cnt  = 0;
    int          bit_idx   = 15;
    logic        prev_sclk = 1'b0;

    int          model_hist[$];
    int          model_temp  = 0;
    int          model_fault = 0;
    int          model_valid = 0;

    temp_sensor_reader #(
        .INPUT_CLK_FREQ(1000),
        .SCLK_FREQ     (100),
        .SAMPLE_RATE_HZ(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sensor_miso (sensor_miso),
        .sensor_cs_n (sensor_cs_n),
        .sensor_sclk (sensor_sclk),
        .temp_data   (temp_data),
        .temp_valid  (temp_valid),
        .sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;

    // Converter model: presents bit 15 on CS fall, next bit after each SCLK fall.
    always @(negedge clk) begin
        if (!prev_sclk && sensor_sclk) rise_cnt++;
        if (sensor_sclk && sensor_cs_n) viol_cnt++;
        if (sensor_cs_n) bit_idx = 15;
        else if (prev_sclk && !sensor_sclk && bit_idx > 0) bit_idx--;
        sensor_miso = cur_frame[bit_idx];
        prev_sclk   = sensor_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reading in 0.1 degC is 2.5x the quarter-degree count, rounded down.
    task automatic model_frame(input logic [15:0] f);
        int raw;
        int s;
        int sum;
        raw = int'(f[14:3]);
        if (f[2]) begin
            model_fault = 1;
            model_valid = 0;
        end else begin
            s = (raw * 10) / 4;
            model_fault = 0;
            model_valid = 1;
`ifdef TEMP_AVG_EN
            if (model_hist.size() == 0) begin
                for (int i = 0; i < 4; i++) model_hist.push_back(s);
            end else begin
                model_hist.push_back(s);
                void'(model_hist.pop_front());
            end
            sum = 0;
            foreach (model_hist[i]) sum += model_hist[i];
            model_temp = sum / 4;
`else
            sum = s;
            model_temp = sum;
`endif
        end
    endtask

    task automatic model_reset();
        model_hist.delete();
        model_temp  = 0;
        model_fault = 0;
    endtask

    task automatic run_frame(input string tag, input logic [15:0] f);
        int n;
        cur_frame = f;
        rise_cnt  = 0;
        model_frame(f);
        n = 0;
        while (sensor_cs_n !== 1'b0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".cs_start"}, 32'(sensor_cs_n), 32'd0);
        n = 0;
        while (sensor_cs_n === 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".cs_end"}, 32'(sensor_cs_n), 32'd1);
        chk({tag, ".lat0"}, 32'(temp_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(temp_valid), 32'(model_valid));
        chk({tag, ".temp"}, 32'(temp_data), 32'(model_temp));
        chk({tag, ".fault"}, 32'(sensor_fault), 32'(model_fault));
        @(negedge clk);
        chk({tag, ".pulse1"}, 32'(temp_valid), 32'd0);
        chk({tag, ".sclk16"}, 32'(rise_cnt), 32'd16);
        chk({tag, ".sclk_idle"}, 32'(viol_cnt), 32'd0);
        $display("frame %s: 0x%04h temp_data=%0d valid_exp=%0d fault=%0d", tag, f, temp_data,
                 model_valid, sensor_fault);
    endtask

    initial begin
        logic [15:0] f;
        int n;

        repeat (3) @(negedge clk);
        chk("rst.cs_n", 32'(sensor_cs_n), 32'd1);
        chk("rst.sclk", 32'(sensor_sclk), 32'd0);
        chk("rst.temp", 32'(temp_data), 32'd0);
        chk("rst.valid", 32'(temp_valid), 32'd0);
        chk("rst.fault", 32'(sensor_fault), 32'd0);
        reset = 1'b0;

        run_frame("t1", 16'h0FA0);
        run_frame("t2", 16'h0648);
        run_frame("t3good", 16'h0FA0);
        run_frame("t3fault", 16'h0FA4);
        run_frame("t3clear", 16'h0FA0);

        // Reset in the middle of a frame.
        cur_frame = 16'h0FA0;
        rise_cnt  = 0;
        n = 0;
        while (rise_cnt < 8 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk("t4.reach8", 32'(rise_cnt >= 8), 32'd1);
        reset = 1'b1;
        #1;
        chk("t4.cs_n", 32'(sensor_cs_n), 32'd1);
        chk("t4.sclk", 32'(sensor_sclk), 32'd0);
        chk("t4.temp", 32'(temp_data), 32'd0);
        chk("t4.fault", 32'(sensor_fault), 32'd0);
        chk("t4.valid", 32'(temp_valid), 32'd0);
        model_reset();
        $display("reset asserted mid-frame after %0d sclk edges", rise_cnt);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_frame("t4after", 16'h0FA0);

        run_frame("t5max", 16'h7FF8);

        // Fresh window for the averaging sequence.
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_frame("t6a", 16'h0C80);
        run_frame("t6b", 16'h0C80);
        run_frame("t6c", 16'h1900);
        run_frame("t6d", 16'h1900);

        for (int i = 0; i < 8; i++) begin
            f = 16'($urandom);
            f[2] = ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rnd%0d", i), f);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
